// File: rtl/pitch_freq_gen.sv
// pitch_freq_gen: turns a note request (channel, semitone, fine tune, gate)
// into an oscillator phase increment. Semitone within the octave indexes a
// 13-entry base table, the fine tune interpolates linearly toward the next
// semitone, and the octave count left-shifts the result with saturation.
// One request is processed at a time; each channel keeps its last value.
module pitch_freq_gen #(
    parameter int NCH     = 4,
    parameter int PITCH_W = 7,
    parameter int FINE_W  = 8,
    parameter int FREQ_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NCH)-1:0]   in_chan,
    input  logic [PITCH_W-1:0]       in_pitch,
    input  logic [FINE_W-1:0]        in_fine,
    input  logic                     in_gate,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_chan,
    output logic [FREQ_W-1:0]        out_freq,
    output logic [NCH*FREQ_W-1:0]    freq_bus
);

    localparam int CH_W    = $clog2(NCH);
    localparam int BASE_W  = 17;                              // widest table entry is 66976
    localparam int OCT_MAX = ((2**PITCH_W) - 1 + 11) / 12;    // ceil((2^PITCH_W-1)/12)
    localparam int SH_W    = FREQ_W + OCT_MAX + 1;            // shifted value before saturation
    localparam int OCT_W   = $clog2(OCT_MAX + 1);
    localparam int PROD_W  = BASE_W + FINE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_LOOKUP,
        S_INTERP,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [CH_W-1:0]    chan_r;
    logic [FINE_W-1:0]  fine_r;
    logic               gate_r;
    logic [PITCH_W-1:0] rem_r;
    logic [OCT_W-1:0]   oct_r;
    logic [BASE_W-1:0]  a_r;
    logic [BASE_W-1:0]  b_r;

    logic               accept;
    logic               div_step;
    logic               chan_ok;

    logic [BASE_W-1:0]  diff;
    logic [PROD_W-1:0]  prod;
    logic [BASE_W-1:0]  f_int;
    logic [SH_W-1:0]    f_sh;
    logic [FREQ_W-1:0]  res;

    // Base phase increments for C..C' (one octave plus the upper neighbour
    // so semitone 11 can interpolate toward the next C).
    function automatic logic [BASE_W-1:0] base_rom(input logic [3:0] idx);
        logic [BASE_W-1:0] v;
        case (idx)
            4'd0:    v = 17'd33488;
            4'd1:    v = 17'd35479;
            4'd2:    v = 17'd37589;
            4'd3:    v = 17'd39824;
            4'd4:    v = 17'd42192;
            4'd5:    v = 17'd44701;
            4'd6:    v = 17'd47359;
            4'd7:    v = 17'd50175;
            4'd8:    v = 17'd53159;
            4'd9:    v = 17'd56320;
            4'd10:   v = 17'd59669;
            4'd11:   v = 17'd63217;
            4'd12:   v = 17'd66976;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Clamp the octave-shifted value to the output width.
    function automatic logic [FREQ_W-1:0] sat_freq(input logic [SH_W-1:0] x);
        if (|x[SH_W-1:FREQ_W]) begin
            return '1;
        end
        return x[FREQ_W-1:0];
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign chan_ok   = ({1'b0, chan_r} < (CH_W + 1)'(NCH));

    // Interpolation, octave shift and saturation of the looked-up operands.
    always_comb begin
        diff  = b_r - a_r;
        prod  = PROD_W'(diff) * PROD_W'(fine_r);
        f_int = a_r + BASE_W'(prod >> FINE_W);
        f_sh  = SH_W'(f_int) << oct_r;
        res   = gate_r ? sat_freq(f_sh) : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a note-off borrows the INTERP slot (result forced
    // to zero) so it reaches DONE one edge after acceptance.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        div_step = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = in_gate ? S_DIV : S_INTERP;
                end
            end
            S_DIV: begin
                if (rem_r >= PITCH_W'(12)) begin
                    div_step = 1'b1;
                end else begin
                    state_nx = S_LOOKUP;
                end
            end
            S_LOOKUP: state_nx = S_INTERP;
            S_INTERP: state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Request latch, repeated-subtraction octave split and registered ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_r <= '0;
            fine_r <= '0;
            gate_r <= 1'b0;
            rem_r  <= '0;
            oct_r  <= '0;
            a_r    <= '0;
            b_r    <= '0;
        end else begin
            if (accept) begin
                chan_r <= in_chan;
                fine_r <= in_fine;
                gate_r <= in_gate;
                rem_r  <= in_pitch;
                oct_r  <= '0;
            end
            if (div_step) begin
                rem_r <= rem_r - PITCH_W'(12);
                oct_r <= oct_r + OCT_W'(1);
            end
            if (state == S_LOOKUP) begin
                a_r <= base_rom(rem_r[3:0]);
                b_r <= base_rom(rem_r[3:0] + 4'd1);
            end
        end
    end

    // Result registers and per-channel hold; loaded on the edge into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_chan <= '0;
            out_freq <= '0;
            freq_bus <= '0;
        end else if (state == S_INTERP) begin
            out_chan <= chan_r;
            out_freq <= res;
            if (chan_ok) begin
                freq_bus[chan_r*FREQ_W +: FREQ_W] <= res;
            end
        end
    end

endmodule

// File: tb/tb_pitch_freq_gen.sv
// Directed bench for pitch_freq_gen. Five channels are instantiated so that
// channel 5 is representable on the 3-bit channel port yet out of range.
module tb_pitch_freq_gen;

    localparam int NCH     = 5;
    localparam int PITCH_W = 7;
    localparam int FINE_W  = 8;
    localparam int FREQ_W  = 24;
    localparam int CH_W    = $clog2(NCH);

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [CH_W-1:0]       in_chan;
    logic [PITCH_W-1:0]    in_pitch;
    logic [FINE_W-1:0]     in_fine;
    logic                  in_gate;
    logic                  out_valid;
    logic [CH_W-1:0]       out_chan;
    logic [FREQ_W-1:0]     out_freq;
    logic [NCH*FREQ_W-1:0] freq_bus;

    int n_chk;
    int n_err;
    logic [FREQ_W-1:0] model [NCH];

    pitch_freq_gen #(
        .NCH(NCH), .PITCH_W(PITCH_W), .FINE_W(FINE_W), .FREQ_W(FREQ_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_chan(in_chan), .in_pitch(in_pitch), .in_fine(in_fine), .in_gate(in_gate),
        .out_valid(out_valid), .out_chan(out_chan), .out_freq(out_freq),
        .freq_bus(freq_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [FREQ_W-1:0] bus_ch(input int k);
        return freq_bus[k*FREQ_W +: FREQ_W];
    endfunction

    task automatic check_bus(input string tag);
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("%s_bus%0d", tag, k), 64'(bus_ch(k)), 64'(model[k]));
        end
    endtask

    task automatic idle_quiet(input string tag, input int n);
        bit pulsed;
        pulsed = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulsed = 1'b1;
        end
        check(tag, 64'(pulsed), 64'd0);
    endtask

    // Send one request, measure edges to the pulse, check result and hold.
    // With poke set, in_valid stays asserted with a second request while busy.
    task automatic run_req(input string tag, input int chan, input int pitch,
                           input int fine, input int gate, input int exp_lat,
                           input int exp_freq, input bit poke);
        int lat;
        bit seen;
        bit rdy_busy;
        @(negedge clk);
        check({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_chan  = CH_W'(chan);
        in_pitch = PITCH_W'(pitch);
        in_fine  = FINE_W'(fine);
        in_gate  = gate[0];
        @(posedge clk);
        #1;
        if (poke) begin
            in_chan  = CH_W'(3);
            in_pitch = '0;
            in_fine  = '0;
            in_gate  = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        seen     = 1'b0;
        rdy_busy = 1'b0;
        lat      = 0;
        for (int e = 1; e <= 40 && !seen; e++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = e;
            end else if (in_ready) begin
                rdy_busy = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (chan < NCH) model[chan] = FREQ_W'(exp_freq);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_freq"}, 64'(out_freq), 64'(exp_freq));
        check({tag, "_chan"}, 64'(out_chan), 64'(chan));
        if (poke) check({tag, "_busy"}, 64'(rdy_busy), 64'd0);
        check_bus(tag);
        @(posedge clk);
        #1;
        check({tag, "_pulse1"}, 64'(out_valid), 64'd0);
        check({tag, "_idle"}, 64'(in_ready), 64'd1);
        check({tag, "_hold"}, 64'(out_freq), 64'(exp_freq));
    endtask

    initial begin
        bit pulsed;
        n_chk    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_chan  = '0;
        in_pitch = '0;
        in_fine  = '0;
        in_gate  = 1'b0;
        for (int k = 0; k < NCH; k++) model[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 64'(in_ready), 64'd1);
        check("rst_vld", 64'(out_valid), 64'd0);
        check("rst_freq", 64'(out_freq), 64'd0);
        check("rst_chan", 64'(out_chan), 64'd0);
        check_bus("rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_req("p9",      2,   9,   0, 1,  3,    56320, 1'b0);
        run_req("p21",     0,  21,   0, 1,  4,   112640, 1'b0);
        run_req("p45",     0,  45,   0, 1,  6,   450560, 1'b0);
        run_req("p107",    0, 107,   0, 1, 11, 16183552, 1'b0);
        run_req("p0f128",  3,   0, 128, 1,  3,    34483, 1'b0);
        run_req("p11f255", 3,  11, 255, 1,  3,    66961, 1'b0);
        run_req("p12",     4,  12,   0, 1,  4,    66976, 1'b0);
        run_req("p108",    0, 108,   0, 1, 12, 16777215, 1'b0);
        run_req("p127",    0, 127, 255, 1, 13, 16777215, 1'b1);
        run_req("p60",     1,  60,   0, 1,  8,  1071616, 1'b1);
        idle_quiet("noqueue", 6);
        check_bus("noqueue");
        run_req("off",     1,  60,   0, 0,  1,        0, 1'b0);
        run_req("ch5",     5,   9,   0, 1,  3,    56320, 1'b0);

        // Reset while the pitch-60 request is still dividing.
        @(negedge clk);
        in_valid = 1'b1;
        in_chan  = '0;
        in_pitch = PITCH_W'(60);
        in_fine  = '0;
        in_gate  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NCH; k++) model[k] = '0;
        check("mid_rdy", 64'(in_ready), 64'd1);
        check("mid_vld", 64'(out_valid), 64'd0);
        check("mid_freq", 64'(out_freq), 64'd0);
        check("mid_chan", 64'(out_chan), 64'd0);
        check_bus("mid");
        pulsed = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (out_valid) pulsed = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_nopulse_rst", 64'(pulsed), 64'd0);
        idle_quiet("mid_nopulse", 12);
        run_req("post",    2,   9,   0, 1,  3,    56320, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
